coin_pulse_conditioner: RTL and testbench
=========================================

// Module: coin_pulse_conditioner
// PURPOSE
//  Front end of the 150-yen vending machine, directly upstream of vend150.
//  - Takes raw, asynchronous, bouncing coin-slot switches: 50 yen and 100 yen.
//  - Produces clean single-cycle pulses c0 (50) and c1 (100) that feed vend150's c0/c1 inputs.
//  - Guarantees at most one pulse per cycle and a minimum spacing between pulses.
//  - Queues at most one coin per denomination and flags same-cycle double insertion as a jam.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive equal synchronized samples required to accept a level change (>=2)
//  GAP_CYCLES       2  minimum idle cycles, outputs low, after every c0/c1/reject pulse (>=1)
//  CNT_W            3  debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  ck      in   1  clock; all state updates on the rising edge
//  res     in   1  synchronous reset, active-high
//  sw50    in   1  raw 50-yen slot switch, asynchronous, may bounce
//  sw100   in   1  raw 100-yen slot switch, asynchronous, may bounce
//  c0      out  1  one-cycle pulse: one 50-yen coin accepted (to vend150 c0)
//  c1      out  1  one-cycle pulse: one 100-yen coin accepted (to vend150 c1)
//  reject  out  1  one-cycle pulse: both coins seen on the same cycle; both discarded
//  ovf     out  1  sticky: a coin arrived while the same denomination was still queued; cleared only by res
// BEHAVIOUR
//  - Reset: while res=1 at a rising edge, the following are cleared to 0:
//      sync FFs, debounced levels, counters, queue, ovf, and outputs c0/c1/reject.
//    The FSM goes to IDLE. Reset mid-pulse or mid-gap aborts the pulse or gap.
//    A switch held high across reset yields exactly one pulse after reset,
//    because the debounced level restarts at 0.
//  - Synchronize: 2-FF synchronizer per input; s = second FF output.
//  - Debounce, per channel:
//    - The counter increments on each edge where s != db; it clears when s == db.
//    - When the count reaches DEBOUNCE_CYCLES, db toggles and the counter clears.
//    - A glitch shorter than DEBOUNCE_CYCLES samples never changes db.
//  - Rise detect: an event occurs on the edge where db goes 0->1. Falls produce no event.
//  - Queue: bits pend50 and pend100, plus an order bit (which denomination arrived first).
//    - 50 event and 100 event on the same edge: reject fires; neither denomination is queued.
//    - Event on a denomination already pending: the event is dropped and ovf is set.
//  - FSM (IDLE, FIRE, GAP):
//    - IDLE: if the queue is non-empty, pop the oldest entry and go to FIRE.
//      A reject event takes precedence over popping.
//    - FIRE: exactly one of c0/c1/reject is high for this one cycle; then go to GAP.
//    - GAP: outputs low for GAP_CYCLES cycles; then go to IDLE.
//      New events are still queued during FIRE and GAP.
//  - Latency: raw rise sampled at edge k, stable, queue empty, FSM in IDLE.
//    The pulse is visible after edge k+2+DEBOUNCE_CYCLES (k+6 at defaults).
//  - Outputs are registered; c0, c1 and reject are mutually exclusive in every cycle.
//  - Throughput: at most one pulse per GAP_CYCLES+1 cycles.
// STRUCTURE
//  - Package coin_pkg:
//    - enum coin_t {COIN_50, COIN_100}: queue order bit
//    - enum state_t {IDLE, FIRE, GAP}
//    - defaults for DEBOUNCE_CYCLES and GAP_CYCLES
//  - Sub-module coin_debounce: synchronizer, debounce counter and rise detect for one channel.
//    Instantiated twice, for sw50 and sw100.
//  - Top level: queue, order bit, FSM, gap counter, output registers, ovf.
// TESTING (ck period 20 ns, defaults)
//  1. Clean insert: res pulse, then sw50 high 10 cycles from edge k
//     -> c0=1 for one cycle after edge k+6; c1, reject and ovf stay 0.
//  2. Bounce: sw100 toggled 1,0,1,0 on alternate cycles, then held high 8 cycles
//     -> exactly one c1 pulse, 6 edges after the final rising sample; no pulse from the toggling.
//  3. Back-to-back: sw50 rise, then sw100 rise 1 cycle later
//     -> c0 pulse, then c1 pulse exactly 3 cycles later (2 gap cycles between).
//  4. Jam: sw50 and sw100 rise on the same cycle
//     -> one reject pulse after edge k+6; no c0 or c1 pulse.
//  5. Overflow: two debounced sw50 inserts while the first is still queued behind a pending 100
//     -> c1 pulse, then a single c0 pulse; ovf=1 and it stays 1 until res.
//  6. Reset mid-operation: assert res during GAP with a coin queued
//     -> queue dropped, all outputs 0 the next cycle, no pulse until a new insert.
//     Then feed the full 50,50,50,100,100 sequence into vend150 and check y0/y1 against the vend150 bench.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and default parameters for the coin-slot front end.
package coin_pkg;

    typedef enum logic {
        COIN_50  = 1'b0,
        COIN_100 = 1'b1
    } coin_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned GAP_CYCLES_DEFAULT      = 2;
    localparam int unsigned CNT_W_DEFAULT           = 3;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-FF synchronizer, integrating debounce, 0->1 detect.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic ck,
    input  logic res,
    input  logic sw,
    output logic rise_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             s;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge ck) begin
        if (res) begin
            meta  <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= sw;
            s    <= meta;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // True on the edge where the debounced level is about to go 0->1.
    assign rise_c = s & ~level & (cnt == CNT_LAST);

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin-slot front end for vend150: clean, spaced, mutually exclusive c0/c1/reject pulses.
module coin_pulse_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned GAP_CYCLES      = GAP_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic ck,
    input  logic res,
    input  logic sw50,
    input  logic sw100,
    output logic c0,
    output logic c1,
    output logic reject,
    output logic ovf
);

    localparam int unsigned    GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic             rise50_c;
    logic             rise100_c;
    logic             jam_c;
    logic             add50_c;
    logic             add100_c;
    logic             slot_c;
    logic             pop_rej_c;
    logic             pop50_c;
    logic             pop100_c;
    logic             fire_c;
    logic             left50_c;
    logic             left100_c;

    logic             pend50;
    logic             pend100;
    logic             rej_pend;
    coin_t            order;
    state_t           state;
    logic [GAP_W-1:0] gap_cnt;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db50 (
        .ck     (ck),
        .res    (res),
        .sw     (sw50),
        .rise_c (rise50_c)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db100 (
        .ck     (ck),
        .res    (res),
        .sw     (sw100),
        .rise_c (rise100_c)
    );

    // Pop decision: the last gap cycle behaves like IDLE so spacing is exactly GAP_CYCLES.
    always_comb begin
        jam_c     = rise50_c & rise100_c;
        add50_c   = rise50_c & ~rise100_c;
        add100_c  = rise100_c & ~rise50_c;
        slot_c    = (state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST));
        pop_rej_c = slot_c & rej_pend;
        pop50_c   = slot_c & ~rej_pend & pend50 & (~pend100 | (order == COIN_50));
        pop100_c  = slot_c & ~rej_pend & pend100 & (~pend50 | (order == COIN_100));
        fire_c    = pop_rej_c | pop50_c | pop100_c;
        left50_c  = pend50 & ~pop50_c;
        left100_c = pend100 & ~pop100_c;
    end

    always_ff @(posedge ck) begin
        if (res) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            pend50   <= 1'b0;
            pend100  <= 1'b0;
            rej_pend <= 1'b0;
            order    <= COIN_50;
            c0       <= 1'b0;
            c1       <= 1'b0;
            reject   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            c0       <= pop50_c;
            c1       <= pop100_c;
            reject   <= pop_rej_c;
            rej_pend <= (rej_pend & ~pop_rej_c) | jam_c;
            pend50   <= left50_c | add50_c;
            pend100  <= left100_c | add100_c;
            if ((add50_c & left50_c) | (add100_c & left100_c)) begin
                ovf <= 1'b1;
            end
            // A newly queued coin is the oldest only if the other one is not still waiting.
            if (add50_c & ~left50_c) begin
                order <= left100_c ? COIN_100 : COIN_50;
            end else if (add100_c & ~left100_c) begin
                order <= left50_c ? COIN_50 : COIN_100;
            end
            case (state)
                IDLE: begin
                    if (fire_c) state <= FIRE;
                end
                FIRE: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= fire_c ? FIRE : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Directed bench for coin_pulse_conditioner; a long-gap second instance exercises overflow.
module tb_coin_pulse_conditioner;

    logic ck;
    logic res;
    logic sw50;
    logic sw100;
    logic c0, c1, reject, ovf;
    logic s_c0, s_c1, s_reject, s_ovf;

    int tests;
    int fails;
    int n_c0, n_c1, n_rej;
    int m_c0, m_c1;
    int b_c0, b_c1, b_rej, b_mc0, b_mc1;

    coin_pulse_conditioner u_dut (
        .ck     (ck),
        .res    (res),
        .sw50   (sw50),
        .sw100  (sw100),
        .c0     (c0),
        .c1     (c1),
        .reject (reject),
        .ovf    (ovf)
    );

    coin_pulse_conditioner #(
        .GAP_CYCLES (12)
    ) u_slow (
        .ck     (ck),
        .res    (res),
        .sw50   (sw50),
        .sw100  (sw100),
        .c0     (s_c0),
        .c1     (s_c1),
        .reject (s_reject),
        .ovf    (s_ovf)
    );

    initial ck = 1'b0;
    always #10 ck = ~ck;

    always @(negedge ck) begin
        n_c0  = n_c0 + int'(c0);
        n_c1  = n_c1 + int'(c1);
        n_rej = n_rej + int'(reject);
        m_c0  = m_c0 + int'(s_c0);
        m_c1  = m_c1 + int'(s_c1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_c0  = n_c0;
        b_c1  = n_c1;
        b_rej = n_rej;
        b_mc0 = m_c0;
        b_mc1 = m_c1;
    endtask

    initial begin
        tests = 0; fails = 0;
        n_c0 = 0; n_c1 = 0; n_rej = 0; m_c0 = 0; m_c1 = 0;
        res = 1'b1; sw50 = 1'b0; sw100 = 1'b0;
        cyc(2);
        chk("rst_c0", c0, 1'b0);
        chk("rst_c1", c1, 1'b0);
        chk("rst_reject", reject, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        res = 1'b0;
        cyc(3);

        // 1: clean 50-yen insert
        snap();
        sw50 = 1'b1;
        cyc(6); chk("t1_early", c0, 1'b0);
        cyc(1); chk("t1_c0", c0, 1'b1); chk("t1_c1", c1, 1'b0); chk("t1_rej", reject, 1'b0);
        cyc(1); chk("t1_c0_end", c0, 1'b0);
        cyc(2); sw50 = 1'b0;
        cyc(14);
        chk_n("t1_n_c0", n_c0 - b_c0, 1);
        chk_n("t1_n_c1", n_c1 - b_c1, 0);
        chk_n("t1_n_rej", n_rej - b_rej, 0);
        chk("t1_ovf", ovf, 1'b0);

        // 2: bouncing 100-yen switch
        snap();
        sw100 = 1'b1; cyc(1); sw100 = 1'b0; cyc(1);
        sw100 = 1'b1; cyc(1); sw100 = 1'b0; cyc(1);
        sw100 = 1'b1;
        cyc(6); chk("t2_early", c1, 1'b0);
        cyc(1); chk("t2_c1", c1, 1'b1); chk("t2_c0", c0, 1'b0);
        cyc(1); chk("t2_c1_end", c1, 1'b0);
        sw100 = 1'b0;
        cyc(14);
        chk_n("t2_n_c1", n_c1 - b_c1, 1);
        chk_n("t2_n_c0", n_c0 - b_c0, 0);

        // 3: back-to-back 50 then 100
        snap();
        sw50 = 1'b1; cyc(1); sw100 = 1'b1;
        cyc(6); chk("t3_c0", c0, 1'b1); chk("t3_c1_a", c1, 1'b0);
        cyc(1); chk("t3_gap1_c0", c0, 1'b0); chk("t3_gap1_c1", c1, 1'b0);
        cyc(1); chk("t3_gap2_c1", c1, 1'b0);
        cyc(1); chk("t3_c1", c1, 1'b1); chk("t3_c0_b", c0, 1'b0);
        cyc(1); chk("t3_c1_end", c1, 1'b0);
        cyc(3); sw50 = 1'b0; sw100 = 1'b0;
        cyc(14);
        chk_n("t3_n_c0", n_c0 - b_c0, 1);
        chk_n("t3_n_c1", n_c1 - b_c1, 1);

        // 4: jam
        snap();
        sw50 = 1'b1; sw100 = 1'b1;
        cyc(7); chk("t4_rej", reject, 1'b1); chk("t4_c0", c0, 1'b0); chk("t4_c1", c1, 1'b0);
        cyc(1); chk("t4_rej_end", reject, 1'b0);
        cyc(4); sw50 = 1'b0; sw100 = 1'b0;
        cyc(14);
        chk_n("t4_n_rej", n_rej - b_rej, 1);
        chk_n("t4_n_c0", n_c0 - b_c0, 0);
        chk_n("t4_n_c1", n_c1 - b_c1, 0);
        chk("t4_ovf", ovf, 1'b0);

        // 5: overflow on the long-gap instance
        res = 1'b1; cyc(2); res = 1'b0;
        chk("t5_rst_ovf", s_ovf, 1'b0);
        cyc(3);
        snap();
        sw100 = 1'b1;
        cyc(1); sw50 = 1'b1;
        cyc(6); chk("t5_s_c1", s_c1, 1'b1); chk("t5_m_c1", c1, 1'b1);
        sw50 = 1'b0;
        cyc(3); chk("t5_m_c0", c0, 1'b1);
        cyc(2); sw50 = 1'b1;
        cyc(5); chk("t5_ovf_pre", s_ovf, 1'b0);
        cyc(1); chk("t5_ovf_set", s_ovf, 1'b1);
        cyc(1); chk("t5_s_c0_pre", s_c0, 1'b0);
        cyc(1); chk("t5_s_c0", s_c0, 1'b1); chk("t5_s_c1_b", s_c1, 1'b0);
        cyc(1); chk("t5_s_c0_end", s_c0, 1'b0);
        cyc(20);
        chk("t5_ovf_sticky", s_ovf, 1'b1);
        chk_n("t5_s_n_c0", m_c0 - b_mc0, 1);
        chk_n("t5_s_n_c1", m_c1 - b_mc1, 1);
        chk_n("t5_m_n_c0", n_c0 - b_c0, 2);
        chk("t5_m_ovf", ovf, 1'b0);
        // reset with sw50 still held: ovf clears, one fresh c0 follows
        res = 1'b1; sw100 = 1'b0;
        cyc(2);
        chk("t5_ovf_clr", s_ovf, 1'b0);
        chk("t5_rst_c0", c0, 1'b0);
        res = 1'b0;
        snap();
        cyc(6); chk("t5_held_early", c0, 1'b0);
        cyc(1); chk("t5_held_c0", c0, 1'b1);
        cyc(1); chk("t5_held_end", c0, 1'b0);
        sw50 = 1'b0;
        cyc(14);
        chk_n("t5_held_n_c0", n_c0 - b_c0, 1);

        // 6: reset during GAP with 100 queued
        sw50 = 1'b1; cyc(1); sw100 = 1'b1;
        cyc(6); chk("t6_c0", c0, 1'b1);
        cyc(1);
        res = 1'b1; sw50 = 1'b0; sw100 = 1'b0;
        cyc(1);
        chk("t6_rst_c0", c0, 1'b0);
        chk("t6_rst_c1", c1, 1'b0);
        chk("t6_rst_rej", reject, 1'b0);
        chk("t6_rst_ovf", ovf, 1'b0);
        cyc(1); chk("t6_no_c1", c1, 1'b0);
        res = 1'b0;
        snap();
        cyc(15);
        chk_n("t6_quiet_c0", n_c0 - b_c0, 0);
        chk_n("t6_quiet_c1", n_c1 - b_c1, 0);
        sw100 = 1'b1;
        cyc(7); chk("t6_new_c1", c1, 1'b1);
        cyc(1); sw100 = 1'b0;
        cyc(14);
        chk_n("t6_n_c1", n_c1 - b_c1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
